// File: rtl/btn_debounce_multi_if.sv
// btn_debounce_multi_if: button pins in, conditioned levels and pulses out
// btn_raw, repeat_en: driven by the board/control side (master)
// btn_level, btn_press, btn_release, btn_long, btn_repeat: driven by the conditioner (slave)
interface btn_debounce_multi_if #(parameter int N_BTN = 5);
  logic [N_BTN-1:0] btn_raw, repeat_en, btn_level, btn_press, btn_release, btn_long, btn_repeat;
  modport master (output btn_raw, repeat_en, input btn_level, btn_press, btn_release, btn_long, btn_repeat);
  modport slave (input btn_raw, repeat_en, output btn_level, btn_press, btn_release, btn_long, btn_repeat);
endinterface

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: per-channel synchroniser, debouncer, press/release pulses, long-press and auto-repeat
// clk: system clock; rst_n: asynchronous active-low reset
// b.btn_raw, b.repeat_en: raw pins and per-channel repeat enable
// b.btn_level: debounced level; b.btn_press/btn_release/btn_long/btn_repeat: single-cycle pulses
module btn_debounce_multi #(
  parameter int N_BTN = 5,
  parameter int DEBOUNCE_CYC = 1_500_000,
  parameter int DB_WIDTH = 24,
  parameter int LONG_CYC = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000,
  parameter int HOLD_WIDTH = 27,
  parameter int IN_ACTIVE_LOW = 0
) (
  input logic clk,
  input logic rst_n,
  btn_debounce_multi_if.slave b
);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  localparam logic [DB_WIDTH-1:0] DB_MAX = DB_WIDTH'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_WIDTH-1:0] LONG_MAX = HOLD_WIDTH'(LONG_CYC - 1);
  localparam logic [HOLD_WIDTH-1:0] REP_MAX = HOLD_WIDTH'(REPEAT_CYC - 1);
  logic [N_BTN-1:0] in, sync1, level, acc, rise, fall, press, rel, lng, rep, long_nxt, rep_nxt;
  logic [DB_WIDTH-1:0] cnt [N_BTN];
  logic [HOLD_WIDTH-1:0] hold_cnt [N_BTN], hold_nxt [N_BTN];
  state_t st [N_BTN], st_nxt [N_BTN];
  assign in = b.btn_raw ^ {N_BTN{IN_ACTIVE_LOW != 0}};
  assign b.btn_level = level;
  assign b.btn_press = press;
  assign b.btn_release = rel;
  assign b.btn_long = lng;
  assign b.btn_repeat = rep;
  // level/cnt act as the second synchroniser stage: they only ever sample sync1,
  // so a new level is accepted DEBOUNCE_CYC edges after it reaches sync1
  always_comb begin
    acc = '0;
    rise = '0;
    fall = '0;
    long_nxt = '0;
    rep_nxt = '0;
    st_nxt = st;
    hold_nxt = hold_cnt;
    for (int i = 0; i < N_BTN; i++) begin
      acc[i] = (sync1[i] != level[i]) && (cnt[i] == DB_MAX);
      rise[i] = acc[i] && sync1[i];
      fall[i] = acc[i] && !sync1[i];
      if (fall[i]) begin
        st_nxt[i] = IDLE;
        hold_nxt[i] = '0;
      end else if (st[i] == IDLE) begin
        st_nxt[i] = rise[i] ? HELD : IDLE;
        hold_nxt[i] = '0;
      end else if (st[i] == HELD) begin
        long_nxt[i] = hold_cnt[i] == LONG_MAX;
        st_nxt[i] = long_nxt[i] ? LONG : HELD;
        hold_nxt[i] = long_nxt[i] ? '0 : hold_cnt[i] + 1'b1;
      end else begin
        rep_nxt[i] = b.repeat_en[i] && (hold_cnt[i] == REP_MAX);
        hold_nxt[i] = (!b.repeat_en[i] || rep_nxt[i]) ? '0 : hold_cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      level <= '0;
      press <= '0;
      rel <= '0;
      lng <= '0;
      rep <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
        hold_cnt[i] <= '0;
        st[i] <= IDLE;
      end
    end else begin
      sync1 <= in;
      level <= level ^ acc;
      press <= rise;
      rel <= fall;
      lng <= long_nxt;
      rep <= rep_nxt;
      st <= st_nxt;
      hold_cnt <= hold_nxt;
      for (int i = 0; i < N_BTN; i++)
        cnt[i] <= (sync1[i] == level[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
endmodule
